// File: rtl/usb_pid_pkg.sv
// usb_pid_pkg: token, data and handshake PID codes (PID[3:2]) and sequencer states
package usb_pid_pkg;
  localparam logic [1:0] TOK_OUT = 2'b00;
  localparam logic [1:0] TOK_IN = 2'b10;
  localparam logic [1:0] TOK_SETUP = 2'b11;
  localparam logic [1:0] PID_DATA0 = 2'b00;
  localparam logic [1:0] PID_DATA1 = 2'b10;
  localparam logic [1:0] HSK_ACK = 2'b00;
  localparam logic [1:0] HSK_NYET = 2'b01;
  localparam logic [1:0] HSK_NAK = 2'b10;
  localparam logic [1:0] HSK_STALL = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_RX_DATA, ST_HSK, ST_TX_DATA, ST_WAIT_ACK} state_t;
endpackage

// File: rtl/transaction_ctrl_if.sv
// transaction_ctrl_if: decoder strobes, endpoint status/strobes and encoder requests around the sequencer
interface transaction_ctrl_if #(parameter int NUM_EP = 4);
  logic trn_start_i;
  logic [1:0] trn_type_i;
  logic [3:0] trn_endpoint_i;
  logic rx_trn_end_i;
  logic [1:0] rx_trn_type_i;
  logic crc_err_i;
  logic trn_hsk_recv_i;
  logic [1:0] trn_hsk_type_i;
  logic [NUM_EP-1:0] ep_rx_ready_i;
  logic [NUM_EP-1:0] ep_tx_ready_i;
  logic [NUM_EP-1:0] ep_halt_i;
  logic [NUM_EP-1:0] ep_toggle_clr_i;
  logic [3:0] ep_sel_o;
  logic ep_setup_o;
  logic ep_rx_commit_o;
  logic ep_rx_discard_o;
  logic ep_tx_commit_o;
  logic ep_tx_retry_o;
  logic hsk_tvalid_o;
  logic hsk_tready_i;
  logic [1:0] hsk_type_o;
  logic tx_start_o;
  logic [1:0] tx_type_o;
  logic tx_done_i;
  modport master (
    input trn_start_i, trn_type_i, trn_endpoint_i, rx_trn_end_i, rx_trn_type_i, crc_err_i,
          trn_hsk_recv_i, trn_hsk_type_i, ep_rx_ready_i, ep_tx_ready_i, ep_halt_i, ep_toggle_clr_i,
          hsk_tready_i, tx_done_i,
    output ep_sel_o, ep_setup_o, ep_rx_commit_o, ep_rx_discard_o, ep_tx_commit_o, ep_tx_retry_o,
           hsk_tvalid_o, hsk_type_o, tx_start_o, tx_type_o
  );
  modport slave (
    output trn_start_i, trn_type_i, trn_endpoint_i, rx_trn_end_i, rx_trn_type_i, crc_err_i,
           trn_hsk_recv_i, trn_hsk_type_i, ep_rx_ready_i, ep_tx_ready_i, ep_halt_i, ep_toggle_clr_i,
           hsk_tready_i, tx_done_i,
    input ep_sel_o, ep_setup_o, ep_rx_commit_o, ep_rx_discard_o, ep_tx_commit_o, ep_tx_retry_o,
          hsk_tvalid_o, hsk_type_o, tx_start_o, tx_type_o
  );
endinterface

// File: rtl/ep_toggle_bank.sv
// ep_toggle_bank: per-endpoint rx/tx DATA0/DATA1 toggles; clear beats set beats flip
module ep_toggle_bank #(parameter int NUM_EP = 4) (
  input logic clock,
  input logic reset,
  input logic [NUM_EP-1:0] rx_flip,
  input logic [NUM_EP-1:0] tx_flip,
  input logic [NUM_EP-1:0] set,
  input logic [NUM_EP-1:0] clr,
  output logic [NUM_EP-1:0] rx_tog,
  output logic [NUM_EP-1:0] tx_tog
);
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_tog <= '0;
      tx_tog <= '0;
    end else begin
      rx_tog <= ((rx_tog ^ rx_flip) | set) & ~clr;
      tx_tog <= ((tx_tog ^ tx_flip) | set) & ~clr;
    end
  end
endmodule

// File: rtl/transaction_ctrl.sv
// transaction_ctrl: device-side USB transaction sequencer (responses, data toggles, turnaround timeout)
module transaction_ctrl
  import usb_pid_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int TIMEOUT = 100
) (
  input logic clock,
  input logic reset,
  transaction_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [NUM_EP-1:0] tok_oh, sel_oh, rx_tog, tx_tog;
  logic tok_ok, tok_halt, tok_rdy, tok_tog, halt, rdy, rx_end, hsk_go, setup_ok, rx_adv, tx_ack, tmo;
  logic [1:0] rx_hsk;
  // one-hot selects are zero for endpoints >= NUM_EP, which doubles as the range check
  always_comb begin
    tok_oh = NUM_EP'(1) << bus.trn_endpoint_i;
    sel_oh = NUM_EP'(1) << bus.ep_sel_o;
    tok_ok = |tok_oh && bus.trn_type_i != 2'b01;
    tok_halt = |(tok_oh & bus.ep_halt_i);
    tok_rdy = |(tok_oh & bus.ep_tx_ready_i);
    tok_tog = |(tok_oh & tx_tog);
    halt = |(sel_oh & bus.ep_halt_i);
    rdy = |(sel_oh & bus.ep_rx_ready_i);
    rx_end = state == ST_RX_DATA && bus.rx_trn_end_i && !bus.trn_start_i;
    hsk_go = !bus.crc_err_i && (!bus.ep_setup_o || bus.rx_trn_type_i == PID_DATA0);
    setup_ok = rx_end && hsk_go && bus.ep_setup_o;
    rx_adv = rx_end && hsk_go && !bus.ep_setup_o && !halt && rdy
             && bus.rx_trn_type_i == {|(sel_oh & rx_tog), 1'b0};
    tx_ack = state == ST_WAIT_ACK && bus.trn_hsk_recv_i && bus.trn_hsk_type_i == HSK_ACK && !bus.trn_start_i;
    tmo = timer == TW'(TIMEOUT - 1);
    rx_hsk = bus.ep_setup_o ? HSK_ACK : halt ? HSK_STALL : !rdy ? HSK_NAK : HSK_ACK;
  end
  ep_toggle_bank #(.NUM_EP(NUM_EP)) u_tog (
    .clock(clock),
    .reset(reset),
    .rx_flip(sel_oh & {NUM_EP{rx_adv}}),
    .tx_flip(sel_oh & {NUM_EP{tx_ack}}),
    .set(sel_oh & {NUM_EP{setup_ok}}),
    .clr(bus.ep_toggle_clr_i),
    .rx_tog(rx_tog),
    .tx_tog(tx_tog)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
      bus.ep_sel_o <= '0;
      bus.ep_setup_o <= 1'b0;
      bus.ep_rx_commit_o <= 1'b0;
      bus.ep_rx_discard_o <= 1'b0;
      bus.ep_tx_commit_o <= 1'b0;
      bus.ep_tx_retry_o <= 1'b0;
      bus.hsk_tvalid_o <= 1'b0;
      bus.hsk_type_o <= HSK_ACK;
      bus.tx_start_o <= 1'b0;
      bus.tx_type_o <= PID_DATA0;
    end else begin
      bus.ep_rx_commit_o <= 1'b0;
      bus.ep_rx_discard_o <= 1'b0;
      bus.ep_tx_commit_o <= 1'b0;
      bus.ep_tx_retry_o <= 1'b0;
      bus.tx_start_o <= 1'b0;
      timer <= timer == TW'(TIMEOUT) ? timer : timer + 1'b1;
      // a token always wins: whatever was in flight is abandoned and the token is decoded as if idle
      if (bus.trn_start_i) begin
        bus.ep_tx_retry_o <= state == ST_WAIT_ACK;
        bus.hsk_tvalid_o <= 1'b0;
        state <= ST_IDLE;
        if (tok_ok) begin
          bus.ep_sel_o <= bus.trn_endpoint_i;
          bus.ep_setup_o <= bus.trn_type_i == TOK_SETUP;
          timer <= '0;
          if (bus.trn_type_i != TOK_IN) begin
            state <= ST_RX_DATA;
          end else if (tok_halt || !tok_rdy) begin
            state <= ST_HSK;
            bus.hsk_tvalid_o <= 1'b1;
            bus.hsk_type_o <= tok_halt ? HSK_STALL : HSK_NAK;
          end else begin
            state <= ST_TX_DATA;
            bus.tx_start_o <= 1'b1;
            bus.tx_type_o <= {tok_tog, 1'b0};
          end
        end
      end else begin
        case (state)
          ST_RX_DATA:
            if (bus.rx_trn_end_i) begin
              state <= hsk_go ? ST_HSK : ST_IDLE;
              bus.hsk_tvalid_o <= hsk_go;
              bus.hsk_type_o <= rx_hsk;
              bus.ep_rx_commit_o <= setup_ok || rx_adv;
              bus.ep_rx_discard_o <= !(setup_ok || rx_adv);
            end else if (tmo) begin
              state <= ST_IDLE;
            end
          ST_HSK:
            if (bus.hsk_tready_i) begin
              state <= ST_IDLE;
              bus.hsk_tvalid_o <= 1'b0;
            end
          ST_TX_DATA:
            if (bus.tx_done_i) begin
              state <= ST_WAIT_ACK;
              timer <= '0;
            end
          ST_WAIT_ACK:
            if (bus.trn_hsk_recv_i || tmo) begin
              state <= ST_IDLE;
              bus.ep_tx_commit_o <= tx_ack;
              bus.ep_tx_retry_o <= !tx_ack;
            end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_transaction_ctrl.sv
// tb_transaction_ctrl: directed vectors with hand-computed expectations for transaction_ctrl
module tb_transaction_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clock = ~clock;
  transaction_ctrl_if #(.NUM_EP(4)) bus ();
  transaction_ctrl #(.NUM_EP(4), .TIMEOUT(100)) dut (.clock(clock), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic token(input logic [1:0] t, input logic [3:0] ep);
    bus.trn_start_i = 1'b1;
    bus.trn_type_i = t;
    bus.trn_endpoint_i = ep;
    tick();
    bus.trn_start_i = 1'b0;
  endtask
  task automatic rx_data(input logic [1:0] pid, input logic crc);
    bus.rx_trn_end_i = 1'b1;
    bus.rx_trn_type_i = pid;
    bus.crc_err_i = crc;
    tick();
    bus.rx_trn_end_i = 1'b0;
    bus.crc_err_i = 1'b0;
  endtask
  task automatic host_hsk(input logic [1:0] t);
    bus.trn_hsk_recv_i = 1'b1;
    bus.trn_hsk_type_i = t;
    tick();
    bus.trn_hsk_recv_i = 1'b0;
  endtask
  task automatic accept();
    bus.hsk_tready_i = 1'b1;
    tick();
    bus.hsk_tready_i = 1'b0;
    check("hsk_drop", 8'(bus.hsk_tvalid_o), 8'h0);
  endtask
  task automatic tx_done();
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i = 1'b0;
  endtask
  initial begin
    bus.trn_start_i = 1'b0;
    bus.trn_type_i = 2'b00;
    bus.trn_endpoint_i = 4'd0;
    bus.rx_trn_end_i = 1'b0;
    bus.rx_trn_type_i = 2'b00;
    bus.crc_err_i = 1'b0;
    bus.trn_hsk_recv_i = 1'b0;
    bus.trn_hsk_type_i = 2'b00;
    bus.ep_rx_ready_i = 4'b1111;
    bus.ep_tx_ready_i = 4'b0011;
    bus.ep_halt_i = 4'b0000;
    bus.ep_toggle_clr_i = 4'b0000;
    bus.hsk_tready_i = 1'b0;
    bus.tx_done_i = 1'b0;
    repeat (3) tick();
    check("rst_hsk_valid", 8'(bus.hsk_tvalid_o), 8'h0);
    check("rst_ep_sel", 8'(bus.ep_sel_o), 8'h0);
    check("rst_setup", 8'(bus.ep_setup_o), 8'h0);
    check("rst_pulses", 8'({bus.ep_rx_commit_o, bus.ep_rx_discard_o, bus.ep_tx_commit_o, bus.ep_tx_retry_o, bus.tx_start_o}), 8'h0);
    reset = 1'b0;
    tick();
    // SETUP EP0 with DATA0: commit + ACK, toggles become DATA1
    token(2'b11, 4'd0);
    check("setup_sel", 8'(bus.ep_sel_o), 8'h0);
    check("setup_flag", 8'(bus.ep_setup_o), 8'h1);
    rx_data(2'b00, 1'b0);
    check("setup_commit", 8'(bus.ep_rx_commit_o), 8'h1);
    check("setup_discard", 8'(bus.ep_rx_discard_o), 8'h0);
    check("setup_hsk_valid", 8'(bus.hsk_tvalid_o), 8'h1);
    check("setup_hsk_type", 8'(bus.hsk_type_o), 8'h0);
    tick();
    check("setup_commit_pulse", 8'(bus.ep_rx_commit_o), 8'h0);
    accept();
    // EP0 tx toggle is DATA1 after SETUP; host NAK rewinds
    token(2'b10, 4'd0);
    check("in0_start", 8'(bus.tx_start_o), 8'h1);
    check("in0_type", 8'(bus.tx_type_o), 8'h2);
    tick();
    check("in0_start_pulse", 8'(bus.tx_start_o), 8'h0);
    tx_done();
    host_hsk(2'b10);
    check("in0_nak_retry", 8'(bus.ep_tx_retry_o), 8'h1);
    check("in0_nak_commit", 8'(bus.ep_tx_commit_o), 8'h0);
    // OUT EP1 DATA0 twice, then DATA1
    token(2'b00, 4'd1);
    check("out1_sel", 8'(bus.ep_sel_o), 8'h1);
    check("out1_setup", 8'(bus.ep_setup_o), 8'h0);
    rx_data(2'b00, 1'b0);
    check("out1a_commit", 8'(bus.ep_rx_commit_o), 8'h1);
    check("out1a_hsk", 8'({bus.hsk_tvalid_o, bus.hsk_type_o}), 8'h4);
    accept();
    token(2'b00, 4'd1);
    rx_data(2'b00, 1'b0);
    check("out1b_commit", 8'(bus.ep_rx_commit_o), 8'h0);
    check("out1b_discard", 8'(bus.ep_rx_discard_o), 8'h1);
    check("out1b_hsk", 8'({bus.hsk_tvalid_o, bus.hsk_type_o}), 8'h4);
    accept();
    token(2'b00, 4'd1);
    rx_data(2'b10, 1'b0);
    check("out1c_commit", 8'(bus.ep_rx_commit_o), 8'h1);
    accept();
    // CRC error: discard, never a handshake
    token(2'b00, 4'd2);
    rx_data(2'b00, 1'b1);
    check("crc_discard", 8'(bus.ep_rx_discard_o), 8'h1);
    check("crc_commit", 8'(bus.ep_rx_commit_o), 8'h0);
    for (int i = 0; i < 3; i++) begin
      check("crc_no_hsk", 8'(bus.hsk_tvalid_o), 8'h0);
      tick();
    end
    // IN EP1 twice: DATA0 then DATA1, both ACKed
    token(2'b10, 4'd1);
    check("in1a_type", 8'({bus.tx_start_o, bus.tx_type_o}), 8'h4);
    tx_done();
    host_hsk(2'b00);
    check("in1a_commit", 8'(bus.ep_tx_commit_o), 8'h1);
    token(2'b10, 4'd1);
    check("in1b_type", 8'({bus.tx_start_o, bus.tx_type_o}), 8'h6);
    tx_done();
    host_hsk(2'b00);
    check("in1b_commit", 8'(bus.ep_tx_commit_o), 8'h1);
    check("in1b_retry", 8'(bus.ep_tx_retry_o), 8'h0);
    // IN EP1 with no host handshake: retry exactly 100 cycles after tx_done
    token(2'b10, 4'd1);
    check("in1c_type", 8'({bus.tx_start_o, bus.tx_type_o}), 8'h4);
    tx_done();
    repeat (99) tick();
    check("tmo_early", 8'(bus.ep_tx_retry_o), 8'h0);
    tick();
    check("tmo_retry", 8'(bus.ep_tx_retry_o), 8'h1);
    token(2'b10, 4'd1);
    check("tmo_toggle_kept", 8'({bus.tx_start_o, bus.tx_type_o}), 8'h4);
    tx_done();
    host_hsk(2'b00);
    check("in1d_commit", 8'(bus.ep_tx_commit_o), 8'h1);
    // IN to halted EP3 with a stalled encoder: STALL held stable
    bus.ep_halt_i = 4'b1000;
    token(2'b10, 4'd3);
    check("stall_start", 8'(bus.tx_start_o), 8'h0);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", 8'({bus.hsk_tvalid_o, bus.hsk_type_o}), 8'h7);
      tick();
    end
    accept();
    bus.ep_halt_i = 4'b0000;
    // endpoint beyond NUM_EP is ignored
    token(2'b10, 4'd5);
    check("bad_ep_sel", 8'(bus.ep_sel_o), 8'h3);
    check("bad_ep_quiet", 8'({bus.tx_start_o, bus.hsk_tvalid_o}), 8'h0);
    // OUT to EP2 that cannot accept: discard + NAK
    bus.ep_rx_ready_i = 4'b1011;
    token(2'b00, 4'd2);
    rx_data(2'b00, 1'b0);
    check("nak_discard", 8'(bus.ep_rx_discard_o), 8'h1);
    check("nak_hsk", 8'({bus.hsk_tvalid_o, bus.hsk_type_o}), 8'h6);
    accept();
    bus.ep_rx_ready_i = 4'b1111;
    // SETUP with DATA1: discard and silence
    token(2'b11, 4'd0);
    rx_data(2'b10, 1'b0);
    check("setup1_discard", 8'({bus.ep_rx_commit_o, bus.ep_rx_discard_o}), 8'h1);
    check("setup1_no_hsk", 8'(bus.hsk_tvalid_o), 8'h0);
    // toggle clear brings EP0 back to DATA0
    bus.ep_toggle_clr_i = 4'b0001;
    tick();
    bus.ep_toggle_clr_i = 4'b0000;
    token(2'b10, 4'd0);
    check("clr_type", 8'({bus.tx_start_o, bus.tx_type_o}), 8'h4);
    tx_done();
    // token while waiting for ACK aborts with retry and starts the new transaction
    token(2'b00, 4'd1);
    check("abort_retry", 8'(bus.ep_tx_retry_o), 8'h1);
    check("abort_sel", 8'(bus.ep_sel_o), 8'h1);
    rx_data(2'b00, 1'b0);
    check("abort_out_commit", 8'(bus.ep_rx_commit_o), 8'h1);
    accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
